pool_mxm_wr_ctrl: RTL and testbench

Writer side of the pooling MXM FIFO. It accepts pooling input words from the upstream loader stream and interleaves two P-element channel halves into the MXM word layout. It writes those words into MXM under almost-full backpressure and counts elements, PE-select slots and vectors so it can signal completion of one pooling instruction. It sits between the pooling data loader and MXM, mirroring the pooling array controller that drains MXM.

---
 rtl/pool_mxm_wr_ctrl_pkg.sv | 32 +++
 rtl/pool_mxm_wr_ctrl_if.sv | 52 +++++
 rtl/pool_interleave.sv | 24 ++
 rtl/pool_mxm_wr_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pool_mxm_wr_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_mxm_wr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pool_mxm_wr_ctrl_pkg
//   Shared definitions for the pooling MXM writer: default geometry, the
//   controller state encoding and the latched instruction-size bundle.
//   No ports; imported by the interface, the interleaver and the top.
// -----------------------------------------------------------------------------
package pool_mxm_wr_ctrl_pkg;

  // Default pooling geometry: P elements per channel half, S PE columns.
  localparam int unsigned POOL_P = 64;
  localparam int unsigned POOL_S = 8;

  // Width of one MXM word in bits (two P-byte channel halves).
  localparam int unsigned POOL_WORD_W = POOL_P * 2 * 8;

  // Width of the instruction size fields.
  localparam int unsigned POOL_SIZE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

  // Instruction sizes captured at start so that upstream changes mid-run
  // cannot disturb the loop bounds.
  typedef struct packed {
    logic [POOL_SIZE_W-1:0] vec_size_m1;
    logic [POOL_SIZE_W-1:0] n_vec_m1;
  } wr_sizes_t;

endpackage

// File: rtl/pool_mxm_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// pool_mxm_wr_ctrl_if
//   Bus bundle between the pooling loader stream, the writer controller and
//   the MXM write port.
//   Signals:
//     in_data          loader word: bytes [0,P) channel A, [P,2P) channel B
//     in_vld / in_rdy  loader handshake
//     mxm_wr_en        MXM write strobe
//     mxm_din          interleaved MXM write data
//     mxm_full         MXM full (error detection only)
//     mxm_almost_full  MXM almost full (flow control)
//   Modports:
//     master  the writer controller
//     slave   the environment (loader + MXM)
// -----------------------------------------------------------------------------
interface pool_mxm_wr_ctrl_if
  import pool_mxm_wr_ctrl_pkg::*;
#(
  parameter int unsigned P = POOL_P
);

  localparam int unsigned W = P * 2 * 8;

  logic [W-1:0] in_data;
  logic         in_vld;
  logic         in_rdy;
  logic         mxm_wr_en;
  logic [W-1:0] mxm_din;
  logic         mxm_full;
  logic         mxm_almost_full;

  modport master (
    input  in_data,
    input  in_vld,
    input  mxm_full,
    input  mxm_almost_full,
    output in_rdy,
    output mxm_wr_en,
    output mxm_din
  );

  modport slave (
    output in_data,
    output in_vld,
    output mxm_full,
    output mxm_almost_full,
    input  in_rdy,
    input  mxm_wr_en,
    input  mxm_din
  );

endinterface

// File: rtl/pool_interleave.sv
// -----------------------------------------------------------------------------
// pool_interleave
//   Pure byte remap from the loader layout (channel A half, then channel B
//   half) to the MXM layout (A/B byte pairs per element). It is the exact
//   inverse of the separation done on the array side of MXM.
//   Ports:
//     i_data  P*16 bits, byte k<P = A[k], byte P+k = B[k]
//     o_data  P*16 bits, byte 2k = A[k], byte 2k+1 = B[k]
// -----------------------------------------------------------------------------
module pool_interleave
  import pool_mxm_wr_ctrl_pkg::*;
#(
  parameter int unsigned P = POOL_P
) (
  input  logic [P*16-1:0] i_data,
  output logic [P*16-1:0] o_data
);

  for (genvar i = 0; i < P; i++) begin : g_elem
    assign o_data[i*16   +: 8] = i_data[i*8     +: 8];
    assign o_data[i*16+8 +: 8] = i_data[(i+P)*8 +: 8];
  end

endmodule

// File: rtl/pool_mxm_wr_ctrl.sv
// -----------------------------------------------------------------------------
// pool_mxm_wr_ctrl
//   Writer side of the pooling MXM FIFO. Accepts loader words while running,
//   interleaves the two channel halves and writes them into MXM one cycle
//   later. Counts select slots, elements and vectors to find the last word of
//   the instruction, then spends one DONE cycle before returning to IDLE.
//   Ports:
//     clk               clock, rising edge
//     rst               synchronous active-high reset
//     start_pulse       one-cycle instruction start, honoured in IDLE only
//     vec_size_minus_1  elements per vector minus 1, latched at start
//     n_vec_minus_1     vectors per instruction minus 1, latched at start
//     bus               loader stream + MXM write port (master view)
//     busy              high in RUN and DONE
//     done_pulse        high in the cycle of the final MXM write
//     ovf_err           sticky: a write was issued while MXM was full
// -----------------------------------------------------------------------------
module pool_mxm_wr_ctrl
  import pool_mxm_wr_ctrl_pkg::*;
#(
  parameter int unsigned P = POOL_P,
  parameter int unsigned S = POOL_S
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_pulse,
  input  logic [POOL_SIZE_W-1:0] vec_size_minus_1,
  input  logic [POOL_SIZE_W-1:0] n_vec_minus_1,
  pool_mxm_wr_ctrl_if.master     bus,
  output logic                   busy,
  output logic                   done_pulse,
  output logic                   ovf_err
);

  localparam int unsigned W        = P * 16;
  localparam int unsigned SLOTS    = S / 2;
  localparam int unsigned SEL_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SLOTS - 1);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  wr_state_e              r_state;
  wr_state_e              w_state_nxt;
  wr_sizes_t              r_sizes;
  logic [SEL_W-1:0]       r_sel_cnt;
  logic [POOL_SIZE_W-1:0] r_ele_cnt;
  logic [POOL_SIZE_W-1:0] r_vec_cnt;
  logic                   r_wr_en;
  logic [W-1:0]           r_din;
  logic                   r_done;
  logic                   r_ovf;

  logic                   w_start;
  logic                   w_in_rdy;
  logic                   w_xfer;
  logic                   w_last_sel;
  logic                   w_last_ele;
  logic                   w_last_vec;
  logic                   w_final;
  logic [W-1:0]           w_din_il;

  // ---------------------------------------------------------------------------
  // Handshake and loop-end decode
  // ---------------------------------------------------------------------------
  assign w_start    = (r_state == ST_IDLE) && start_pulse;

  // Almost-full leaves at least two free slots, enough to absorb the one
  // write already in the output register when backpressure arrives.
  assign w_in_rdy   = (r_state == ST_RUN) && !bus.mxm_almost_full;
  assign w_xfer     = bus.in_vld && w_in_rdy;

  assign w_last_sel = (r_sel_cnt == SEL_LAST);
  assign w_last_ele = (r_ele_cnt == r_sizes.vec_size_m1);
  assign w_last_vec = (r_vec_cnt == r_sizes.n_vec_m1);
  assign w_final    = w_xfer && w_last_sel && w_last_ele && w_last_vec;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first guarantees every path drives the
  // output, so no latch is inferred for a missing branch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start_pulse) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_final)     w_state_nxt = ST_DONE;
      ST_DONE:                  w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Size latch and nested loop counters (select slot -> element -> vector)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sizes   <= '0;
      r_sel_cnt <= '0;
      r_ele_cnt <= '0;
      r_vec_cnt <= '0;
    end else if (w_start) begin
      r_sizes.vec_size_m1 <= vec_size_minus_1;
      r_sizes.n_vec_m1    <= n_vec_minus_1;
      r_sel_cnt           <= '0;
      r_ele_cnt           <= '0;
      r_vec_cnt           <= '0;
    end else if (w_xfer) begin
      if (w_last_sel) begin
        r_sel_cnt <= '0;
        if (w_last_ele) begin
          r_ele_cnt <= '0;
          r_vec_cnt <= r_vec_cnt + 1'b1;
        end else begin
          r_ele_cnt <= r_ele_cnt + 1'b1;
        end
      end else begin
        r_sel_cnt <= r_sel_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte interleave
  // ---------------------------------------------------------------------------
  pool_interleave #(
    .P (P)
  ) u_interleave (
    .i_data (bus.in_data),
    .o_data (w_din_il)
  );

  // ---------------------------------------------------------------------------
  // Registered MXM write port, completion pulse and overflow flag
  // ---------------------------------------------------------------------------
  // NOTE: the write data register is reset as well so MXM never sees stale
  // or undefined bytes after reset; it only loads on a transfer otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en <= 1'b0;
      r_din   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_din <= w_din_il;
      end
      // Rises together with the final write, i.e. in the DONE cycle.
      r_done <= w_final;
      if (w_start) begin
        r_ovf <= 1'b0;
      end else if (r_wr_en && bus.mxm_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_rdy    = w_in_rdy;
  assign bus.mxm_wr_en = r_wr_en;
  assign bus.mxm_din   = r_din;
  assign busy          = (r_state != ST_IDLE);
  assign done_pulse    = r_done;
  assign ovf_err       = r_ovf;

endmodule

// File: tb/tb_pool_mxm_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pool_mxm_wr_ctrl
//   Scoreboard bench for pool_mxm_wr_ctrl. The driver pushes every word it
//   expects to be accepted (interleaved by a reference byte formula, tagged
//   with the cycle its write must appear in and whether it is the last word)
//   and a separate monitor pops and compares whenever MXM is written.
// -----------------------------------------------------------------------------
module tb_pool_mxm_wr_ctrl;
  import pool_mxm_wr_ctrl_pkg::*;

  localparam int P = 64;
  localparam int S = 8;
  localparam int W = P * 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pulse;
  logic [15:0] vsz;
  logic [15:0] nvec;
  logic        busy;
  logic        done_pulse;
  logic        ovf_err;

  pool_mxm_wr_ctrl_if #(.P(P)) bus ();

  pool_mxm_wr_ctrl #(
    .P (P),
    .S (S)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_pulse      (start_pulse),
    .vec_size_minus_1 (vsz),
    .n_vec_minus_1    (nvec),
    .bus              (bus),
    .busy             (busy),
    .done_pulse       (done_pulse),
    .ovf_err          (ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      for (int j = 0; j < W/8; j++) begin
        if (act[8*j +: 8] !== req[8*j +: 8]) begin
          $display("FAIL %s: byte %0d is %0h, expected %0h (t=%0t)",
                   name, j, act[8*j +: 8], req[8*j +: 8], $time);
          break;
        end
      end
    end
  endtask

  // Reference remap: MXM byte 2i is channel A element i, byte 2i+1 is
  // channel B element i.
  function automatic logic [W-1:0] ref_interleave(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < P; i++) begin
      r[16*i   +: 8] = d[8*i     +: 8];
      r[16*i+8 +: 8] = d[8*(i+P) +: 8];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] d;
    for (int k = 0; k < W/32; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per MXM write
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mxm_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(bus.mxm_wr_en), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_word("mxm_din", bus.mxm_din, e.data);
          check("write_cycle", 64'(cyc), 64'(e.cyc));
          check("done_pulse_on_write", 64'(done_pulse), 64'(e.last));
        end
      end else if (done_pulse !== 1'b0) begin
        check("done_pulse_without_write", 64'(done_pulse), 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_rdy"},     64'(bus.in_rdy),    64'd0);
    check({tag, "_mxm_wr_en"},  64'(bus.mxm_wr_en), 64'd0);
    check({tag, "_din_zero"},   64'(bus.mxm_din != '0), 64'd0);
    check({tag, "_busy"},       64'(busy),          64'd0);
    check({tag, "_done_pulse"}, 64'(done_pulse),    64'd0);
    check({tag, "_ovf_err"},    64'(ovf_err),       64'd0);
  endtask

  // One instruction.
  //   mode 0: in_vld=1, almost_full=0; mode 1: almost_full toggles every 3
  //   cycles with random in_vld; mode 2: both random.
  //   count_first: first word uses byte k = k, checked by a byte formula.
  //   poke_start: start_pulse issued during RUN and during DONE.
  //   abort_after: if nonzero, reset after that many transfers.
  task automatic run_instr(input int v, input int n, input int mode,
                           input bit count_first, input bit poke_start,
                           input int abort_after);
    int           total, left, xfers, budget;
    logic         vld, af;
    logic [W-1:0] d, e;
    total = (n + 1) * (v + 1) * (S / 2);
    left  = total;
    xfers = 0;
    budget = 0;

    vsz = 16'(v);
    nvec = 16'(n);
    start_pulse = 1'b1;
    bus.in_vld = 1'b0;
    tick();
    start_pulse = 1'b0;
    check("ovf_clear_on_start", 64'(ovf_err), 64'd0);

    while (left > 0 && budget < 2000) begin
      case (mode)
        0:       begin vld = 1'b1; af = 1'b0; end
        1:       begin vld = ($urandom_range(0, 3) != 0); af = ((budget / 3) % 2) == 1; end
        default: begin vld = ($urandom_range(0, 3) != 0); af = ($urandom_range(0, 3) == 0); end
      endcase
      d = rand_word();
      e = ref_interleave(d);
      if (count_first && xfers == 0) begin
        for (int k = 0; k < W/8; k++) d[8*k +: 8] = 8'(k);
        for (int j = 0; j < W/8; j++) e[8*j +: 8] = (j % 2 == 0) ? 8'(j/2) : 8'(P + j/2);
      end
      bus.in_data         = d;
      bus.in_vld          = vld;
      bus.mxm_almost_full = af;
      if (mode != 0) begin
        vsz  = 16'($urandom);
        nvec = 16'($urandom);
      end
      start_pulse = poke_start && (budget == 1);
      #1;
      check("in_rdy_run", 64'(bus.in_rdy), 64'(!af));
      check("busy_run", 64'(busy), 64'd1);
      if (vld && !af) begin
        exp_q.push_back('{data: e, last: (left == 1), cyc: cyc + 1});
        left--;
        xfers++;
      end
      tick();
      budget++;
      if (abort_after > 0 && xfers == abort_after) break;
    end
    start_pulse = 1'b0;
    bus.in_vld = 1'b0;
    bus.mxm_almost_full = 1'b0;

    if (abort_after > 0) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_values("after_midrun_rst");
      tick();
      return;
    end

    check("words_accepted", 64'(total - left), 64'(total));

    // DONE cycle: nothing accepted even with a valid word offered.
    bus.in_vld = 1'b1;
    start_pulse = poke_start;
    #1;
    check("busy_done", 64'(busy), 64'd1);
    check("in_rdy_done", 64'(bus.in_rdy), 64'd0);
    tick();
    bus.in_vld = 1'b0;
    start_pulse = 1'b0;
    check("busy_idle", 64'(busy), 64'd0);
    check("ovf_after_run", 64'(ovf_err), 64'(bus.mxm_full));
    tick();
    check("still_idle", 64'(busy), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    start_pulse = 1'b0;
    vsz = '0;
    nvec = '0;
    bus.in_data = '0;
    bus.in_vld = 1'b0;
    bus.mxm_full = 1'b0;
    bus.mxm_almost_full = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    run_instr(2, 1, 0, 1'b1, 1'b0, 0);   // baseline 24 words, interleave pattern
    run_instr(2, 1, 1, 1'b0, 1'b0, 0);   // almost_full toggling every 3 cycles
    run_instr(0, 0, 0, 1'b0, 1'b1, 0);   // minimum size, ignored starts
    run_instr(2, 1, 0, 1'b0, 1'b0, 10);  // reset after 10 transfers
    run_instr(2, 1, 0, 1'b0, 1'b0, 0);   // full run after reset

    bus.mxm_full = 1'b1;                 // overflow detection
    run_instr(0, 0, 2, 1'b0, 1'b0, 0);
    bus.mxm_full = 1'b0;
    repeat (3) tick();
    check("ovf_sticky", 64'(ovf_err), 64'd1);
    run_instr(1, 0, 2, 1'b0, 1'b0, 0);

    repeat (4) begin
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), 2, 1'b0,
                1'($urandom_range(0, 1)), 0);
    end

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
